// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request arbiter: FSM encoding and default sizes.
package irq_pkg;

    localparam int unsigned IRQ_NUM_SRC = 20;
    localparam int unsigned IRQ_IDX_W   = 5;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder: index 0 has the highest priority.
module irq_prio_enc #(
    parameter int unsigned N     = 20,
    parameter int unsigned IDX_W = 5
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        valid = |vec;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_request_arbiter.sv
// Edge-detecting interrupt collector presenting one request at a time to the CPU
// through a req/ack/eret handshake.
module irq_request_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = IRQ_NUM_SRC,
    parameter int unsigned IDX_W   = IRQ_IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               global_en,
    input  logic               irq_ack,
    input  logic               eret,
    output logic               irq_req,
    output logic [IDX_W-1:0]   irq_id,
    output logic               in_service,
    output logic               any_pending,
    output logic [NUM_SRC-1:0] pending
);

    irq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] eligible;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;

    assign rise     = irq_src & ~prev_q;
    assign eligible = pending_q & irq_mask;

    irq_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec   (eligible),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Clearing the accepted line; a simultaneous new edge on it keeps the flag set.
    always_comb begin
        clr = '0;
        if ((state_q == IRQ_REQ) && irq_ack) begin
            clr = NUM_SRC'(1) << id_q;
        end
        pending_d = rise | (pending_q & ~clr);
    end

    // Next-state logic; the presented index is frozen from REQ until the next IDLE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IRQ_IDLE: begin
                if (global_en && sel_valid) begin
                    state_d = IRQ_REQ;
                    id_d    = sel_idx;
                end
            end
            IRQ_REQ: begin
                if (irq_ack) begin
                    state_d = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                if (eret) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IRQ_IDLE;
            id_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            prev_q    <= irq_src;
            pending_q <= pending_d;
        end
    end

    assign irq_req     = (state_q == IRQ_REQ);
    assign in_service  = (state_q == IRQ_SERVICE);
    assign irq_id      = id_q;
    assign pending     = pending_q;
    assign any_pending = sel_valid;

endmodule

// File: tb/tb_irq_request_arbiter.sv
// Directed bench for irq_request_arbiter with a queue of expected output snapshots.
module tb_irq_request_arbiter;
    import irq_pkg::*;

    localparam int unsigned N = IRQ_NUM_SRC;
    localparam int unsigned W = IRQ_IDX_W;

    typedef struct {
        string          tag;
        logic           req;
        logic           svc;
        logic [W-1:0]   id;
        logic [N-1:0]   pend;
        logic           anyp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_src;
    logic [N-1:0] irq_mask;
    logic         global_en;
    logic         irq_ack;
    logic         eret;
    logic         irq_req;
    logic [W-1:0] irq_id;
    logic         in_service;
    logic         any_pending;
    logic [N-1:0] pending;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    irq_request_arbiter #(
        .NUM_SRC (N),
        .IDX_W   (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .global_en   (global_en),
        .irq_ack     (irq_ack),
        .eret        (eret),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .in_service  (in_service),
        .any_pending (any_pending),
        .pending     (pending)
    );

    function automatic logic [N-1:0] b(input int unsigned i);
        return N'(1) << i;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic req, input logic svc,
                        input logic [W-1:0] id, input logic [N-1:0] pend);
        exp_t e;
        e.tag  = tag;
        e.req  = req;
        e.svc  = svc;
        e.id   = id;
        e.pend = pend;
        e.anyp = |(pend & irq_mask);
        sb.push_back(e);
    endtask

    task automatic cmp1(input string tag, input string fld, input logic [31:0] obs,
                        input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb.pop_front();
        cmp1(e.tag, "irq_req",     32'(irq_req),     32'(e.req));
        cmp1(e.tag, "in_service",  32'(in_service),  32'(e.svc));
        cmp1(e.tag, "irq_id",      32'(irq_id),      32'(e.id));
        cmp1(e.tag, "pending",     32'(pending),     32'(e.pend));
        cmp1(e.tag, "any_pending", 32'(any_pending), 32'(e.anyp));
    endtask

    // Ack the presented request, then return from the handler.
    task automatic serve(input string tag, input logic [W-1:0] id, input logic [N-1:0] pend_after);
        irq_ack = 1'b1;
        push({tag, "_svc"}, 1'b0, 1'b1, id, pend_after);
        cyc();
        check();
        irq_ack = 1'b0;
        eret    = 1'b1;
        push({tag, "_idle"}, 1'b0, 1'b0, id, pend_after);
        cyc();
        check();
        eret = 1'b0;
    endtask

    initial begin
        // Reset with line 3 held high through release
        rst_n     = 1'b0;
        irq_src   = b(3);
        irq_mask  = '1;
        global_en = 1'b1;
        irq_ack   = 1'b0;
        eret      = 1'b0;
        repeat (3) cyc();
        push("rst", 1'b0, 1'b0, '0, '0);
        check();
        rst_n = 1'b1;
        push("rst_pend", 1'b0, 1'b0, '0, b(3));
        cyc();
        check();
        push("rst_req", 1'b1, 1'b0, W'(3), b(3));
        cyc();
        check();
        serve("rst3", W'(3), '0);
        push("level_once", 1'b0, 1'b0, W'(3), '0);
        repeat (2) cyc();
        check();

        // Priority and freeze
        irq_src = irq_src | b(7) | b(12);
        push("pri_pend", 1'b0, 1'b0, W'(3), b(7) | b(12));
        cyc();
        check();
        push("pri_req7", 1'b1, 1'b0, W'(7), b(7) | b(12));
        cyc();
        check();
        irq_src = irq_src | b(2);
        push("pri_freeze", 1'b1, 1'b0, W'(7), b(2) | b(7) | b(12));
        cyc();
        check();
        serve("pri7", W'(7), b(2) | b(12));
        push("pri_req2", 1'b1, 1'b0, W'(2), b(2) | b(12));
        cyc();
        check();
        serve("pri2", W'(2), b(12));
        push("pri_req12", 1'b1, 1'b0, W'(12), b(12));
        cyc();
        check();
        serve("pri12", W'(12), '0);

        // Mask and global enable
        irq_mask[5] = 1'b0;
        irq_src     = irq_src | b(5);
        push("msk_pend", 1'b0, 1'b0, W'(12), b(5));
        cyc();
        check();
        push("msk_idle", 1'b0, 1'b0, W'(12), b(5));
        cyc();
        check();
        irq_mask[5] = 1'b1;
        push("msk_anyp", 1'b0, 1'b0, W'(12), b(5));
        #1;
        check();
        push("msk_req5", 1'b1, 1'b0, W'(5), b(5));
        cyc();
        check();
        serve("msk5", W'(5), '0);
        global_en = 1'b0;
        irq_src   = irq_src | b(6);
        push("gen_pend", 1'b0, 1'b0, W'(5), b(6));
        cyc();
        check();
        push("gen_idle", 1'b0, 1'b0, W'(5), b(6));
        repeat (3) cyc();
        check();
        global_en = 1'b1;
        push("gen_req6", 1'b1, 1'b0, W'(6), b(6));
        cyc();
        check();
        serve("gen6", W'(6), '0);

        // Set/clear collision on line 4
        irq_src = irq_src | b(4);
        push("col_pend", 1'b0, 1'b0, W'(6), b(4));
        cyc();
        check();
        push("col_req", 1'b1, 1'b0, W'(4), b(4));
        cyc();
        check();
        irq_src = irq_src & ~b(4);
        push("col_hold", 1'b1, 1'b0, W'(4), b(4));
        cyc();
        check();
        irq_src = irq_src | b(4);
        irq_ack = 1'b1;
        push("col_svc", 1'b0, 1'b1, W'(4), b(4));
        cyc();
        check();
        irq_ack = 1'b0;
        eret    = 1'b1;
        push("col_idle", 1'b0, 1'b0, W'(4), b(4));
        cyc();
        check();
        eret = 1'b0;
        push("col_req2", 1'b1, 1'b0, W'(4), b(4));
        cyc();
        check();
        serve("col4", W'(4), '0);

        // Handshake misuse
        irq_ack = 1'b1;
        push("hs_ack_idle", 1'b0, 1'b0, W'(4), '0);
        cyc();
        check();
        irq_ack = 1'b0;
        irq_src = irq_src | b(9);
        push("hs_pend", 1'b0, 1'b0, W'(4), b(9));
        cyc();
        check();
        push("hs_req9", 1'b1, 1'b0, W'(9), b(9));
        cyc();
        check();
        eret = 1'b1;
        push("hs_eret_req", 1'b1, 1'b0, W'(9), b(9));
        cyc();
        check();
        irq_ack = 1'b1;
        push("hs_both", 1'b0, 1'b1, W'(9), '0);
        cyc();
        check();
        irq_ack = 1'b0;
        eret    = 1'b0;
        push("hs_svc_hold", 1'b0, 1'b1, W'(9), '0);
        cyc();
        check();
        eret = 1'b1;
        push("hs_idle", 1'b0, 1'b0, W'(9), '0);
        cyc();
        check();
        eret = 1'b0;

        // Asynchronous reset while in SERVICE
        irq_src = irq_src | b(10);
        push("ar_pend", 1'b0, 1'b0, W'(9), b(10));
        cyc();
        check();
        push("ar_req", 1'b1, 1'b0, W'(10), b(10));
        cyc();
        check();
        irq_ack = 1'b1;
        irq_src = irq_src | b(11);
        push("ar_svc", 1'b0, 1'b1, W'(10), b(11));
        cyc();
        check();
        irq_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        push("ar_async", 1'b0, 1'b0, '0, '0);
        #1;
        check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
